// File: rtl/stim_seq_pkg.sv
// Shared types and default sizing for the stimulus replay engine.
package stim_seq_pkg;

   localparam int unsigned DEF_WIDTH = 2;
   localparam int unsigned DEF_DEPTH = 11;
   localparam int unsigned DEF_CNT_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/stim_seq_mem.sv
// Stimulus table: DEPTH x WIDTH register array, synchronous write, asynchronous read.
module stim_seq_mem #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 11,
   parameter int unsigned AW    = 4
) (
   input  logic             clock,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data_c
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Contents survive reset so a program can be replayed after a system reset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/stim_sequencer.sv
// Stimulus replay engine: presents one stored vector per clock from a loadable table.
// Optional wrap-around replay is enabled with STIM_SEQ_LOOP_EN.
module stim_sequencer
   import stim_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned AW    = $clog2(DEPTH),
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW:0]      len,
   input  logic             start,
   input  logic             stop,
`ifdef STIM_SEQ_LOOP_EN
   input  logic             loop,
`endif
   output logic [WIDTH-1:0] stim,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pc
);

   localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);

   state_t           state_q, state_d;
   logic [AW:0]      addr_q, addr_d;
   logic [AW:0]      len_q, len_d;
   logic             loop_q, loop_d;
   logic [WIDTH-1:0] stim_d;
   logic             valid_d, busy_d, done_d;
   logic [CNT_W-1:0] pc_d;

   logic [AW:0]      eff_len_c;
   logic             start_ok_c;
   logic             in_range_c;
   logic             loop_req_c;
   logic             mem_we_c;
   logic [AW-1:0]    rd_addr_c;
   logic [WIDTH-1:0] rd_data_c;

   assign eff_len_c  = (len > DEPTH_A) ? DEPTH_A : len;
   assign start_ok_c = start && !stop;
   assign in_range_c = addr_q < len_q;
`ifdef STIM_SEQ_LOOP_EN
   assign loop_req_c = loop;
`else
   assign loop_req_c = 1'b0;
`endif

   // Host writes are locked out while a replay is in progress.
   assign mem_we_c  = wr_en && reset && !busy && ({1'b0, wr_addr} < DEPTH_A);
   assign rd_addr_c = (state_q == RUN && in_range_c) ? addr_q[AW-1:0] : '0;

   stim_seq_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clock     (clock),
      .wr_en     (mem_we_c),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr   (rd_addr_c),
      .rd_data_c (rd_data_c)
   );

   // State and output registers.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         loop_q  <= 1'b0;
         stim    <= '0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         pc      <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         loop_q  <= loop_d;
         stim    <= stim_d;
         valid   <= valid_d;
         busy    <= busy_d;
         done    <= done_d;
         pc      <= pc_d;
      end
   end

   // Next-state logic; stop beats both start and normal completion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_ok_c) begin
               state_d = (eff_len_c == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (!in_range_c && !loop_q) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values for the registered outputs and datapath.
   always_comb begin
      addr_d  = addr_q;
      len_d   = len_q;
      loop_d  = loop_q;
      stim_d  = stim;
      valid_d = valid;
      pc_d    = pc;
      busy_d  = (state_d == RUN);
      done_d  = (state_d == DONE);
      case (state_q)
         IDLE: begin
            if (start_ok_c) begin
               len_d  = eff_len_c;
               loop_d = loop_req_c;
               addr_d = '0;
               pc_d   = '0;
               if (eff_len_c != '0) begin
                  stim_d  = rd_data_c;
                  valid_d = 1'b1;
                  addr_d  = (AW+1)'(1);
                  pc_d    = CNT_W'(1);
               end
            end
         end
         RUN: begin
            if (stop) begin
               valid_d = 1'b0;
               addr_d  = '0;
            end else if (in_range_c) begin
               stim_d = rd_data_c;
               addr_d = addr_q + (AW+1)'(1);
               pc_d   = pc + CNT_W'(1);
            end else if (loop_q) begin
               // Wrap straight back to entry 0 with no idle cycle.
               stim_d = rd_data_c;
               addr_d = (AW+1)'(1);
               pc_d   = pc + CNT_W'(1);
            end else begin
               valid_d = 1'b0;
               addr_d  = '0;
            end
         end
         DONE: begin
            valid_d = 1'b0;
         end
         default: begin
            valid_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_stim_sequencer.sv
// Self-checking bench for stim_sequencer: index-based reference model plus directed scenarios.
module tb_stim_sequencer;

   localparam int WIDTH = 2;
   localparam int DEPTH = 11;
   localparam int AW    = 4;
   localparam int CNT_W = 32;

`ifdef STIM_SEQ_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             wr_en = 1'b0;
   logic [AW-1:0]    wr_addr = '0;
   logic [WIDTH-1:0] wr_data = '0;
   logic [AW:0]      len = '0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             loop = 1'b0;
   logic [WIDTH-1:0] stim;
   logic             valid, busy, done;
   logic [CNT_W-1:0] pc;

   int n_vec = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   always #5 clock = ~clock;

   stim_sequencer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW),
      .CNT_W (CNT_W)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .len     (len),
      .start   (start),
      .stop    (stop),
`ifdef STIM_SEQ_LOOP_EN
      .loop    (loop),
`endif
      .stim    (stim),
      .valid   (valid),
      .busy    (busy),
      .done    (done),
      .pc      (pc)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks how many vectors this run has presented (k) and
   // derives the next vector as table[k mod L].
   logic [WIDTH-1:0] m_tab [DEPTH];
   logic [WIDTH-1:0] m_stim = '0;
   logic [CNT_W-1:0] m_pc = '0;
   bit               m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_loop = 1'b0;
   int               m_len = 0, m_k = 0;

   initial begin
      for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
   end

   always @(posedge clock) begin
      bit was_busy;
      was_busy = m_busy;
      if (!reset) begin
         m_busy = 0; m_valid = 0; m_done = 0; m_stim = '0; m_pc = '0; m_k = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (!m_busy) begin
         if (start && !stop) begin
            m_len  = (int'(len) > DEPTH) ? DEPTH : int'(len);
            m_loop = LOOP_EN && loop;
            m_k    = 0;
            m_pc   = '0;
            if (m_len == 0) begin
               m_done = 1;
            end else begin
               m_busy = 1; m_valid = 1; m_stim = m_tab[0]; m_k = 1; m_pc = 1;
            end
         end
      end else if (stop) begin
         m_busy = 0; m_valid = 0;
      end else if (m_k == m_len && !m_loop) begin
         m_busy = 0; m_valid = 0; m_done = 1;
      end else begin
         m_stim = m_tab[m_k % m_len];
         m_k++;
         m_pc++;
      end
      if (reset && wr_en && !was_busy && int'(wr_addr) < DEPTH)
         m_tab[wr_addr] = wr_data;
   end

   // Every-cycle comparison against the model.
   always @(negedge clock) begin
      if (chk_on) begin
         chk("cyc_stim",  32'(stim),  32'(m_stim));
         chk("cyc_valid", 32'(valid), 32'(m_valid));
         chk("cyc_busy",  32'(busy),  32'(m_busy));
         chk("cyc_done",  32'(done),  32'(m_done));
         chk("cyc_pc",    pc,         m_pc);
      end
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic pulse_start(input int n);
      len   = 5'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wr(input int a, input int d);
      wr_en   = 1'b1;
      wr_addr = 4'(a);
      wr_data = 2'(d);
      tick();
      wr_en   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      int nv, nd;
      repeat (2) tick();
      reset  = 1'b1;
      chk_on = 1'b1;
      chk("rst_stim", 32'(stim), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_pc", pc, 0);

      for (int i = 0; i < DEPTH; i++) wr(i, i % 4);
      wr(11, 1);

      // One-shot full table.
      pulse_start(11);
      for (int i = 0; i < 11; i++) begin
         chk("full_stim", 32'(stim), 32'(i % 4));
         chk("full_valid", 32'(valid), 1);
         tick();
      end
      chk("full_done", 32'(done), 1);
      chk("full_valid_end", 32'(valid), 0);
      chk("full_pc", pc, 11);
      chk("full_hold", 32'(stim), 2);
      tick();
      chk("full_done_clr", 32'(done), 0);

      // len = 1
      pulse_start(1);
      chk("len1_stim", 32'(stim), 0);
      chk("len1_pc", pc, 1);
      tick();
      chk("len1_done", 32'(done), 1);
      tick();

      // len = 0
      pulse_start(0);
      chk("len0_done", 32'(done), 1);
      chk("len0_valid", 32'(valid), 0);
      chk("len0_pc", pc, 0);
      tick();

      // len = 15 clamps to DEPTH
      pulse_start(15);
      nv = 0; nd = 0;
      repeat (14) begin
         if (valid) nv++;
         if (done) nd++;
         tick();
      end
      chk("len15_vectors", 32'(nv), 11);
      chk("len15_dones", 32'(nd), 1);

      // stop on the 5th RUN cycle
      pulse_start(11);
      repeat (4) tick();
      chk("stop_pc_before", pc, 5);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_valid", 32'(valid), 0);
      chk("stop_busy", 32'(busy), 0);
      chk("stop_pc", pc, 5);
      tick();
      chk("stop_no_done", 32'(done), 0);

      // start + stop in IDLE
      start = 1'b1; stop = 1'b1; len = 5'd11;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("ss_busy", 32'(busy), 0);
      tick();

      // start during RUN and DONE ignored, restart right after done
      pulse_start(3);
      start = 1'b1; len = 5'd11;
      tick();
      start = 1'b0;
      tick();
      chk("rerun_pc", pc, 3);
      tick();
      chk("rerun_done", 32'(done), 1);
      start = 1'b1; len = 5'd2;
      tick();
      chk("done_start_ign", 32'(busy), 0);
      tick();
      start = 1'b0;
      chk("restart_valid", 32'(valid), 1);
      chk("restart_pc", pc, 1);
      repeat (3) tick();

      // write during RUN is dropped
      pulse_start(11);
      wr(2, 3);
      repeat (12) tick();
      pulse_start(4);
      tick(); tick();
      chk("wrblk_run", 32'(stim), 2);
      repeat (3) tick();

      // idle writes land; write alongside start lands but replay sees old entry 0
      wr(2, 3);
      wr(11, 0);
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 2'd3;
      pulse_start(4);
      wr_en = 1'b0;
      chk("wrstart_old", 32'(stim), 0);
      tick(); tick();
      chk("wridle_new", 32'(stim), 3);
      repeat (3) tick();
      pulse_start(1);
      chk("wrstart_new", 32'(stim), 3);
      repeat (2) tick();
      wr(0, 0);
      wr(2, 2);

      // reset mid-run, table intact afterwards
      pulse_start(11);
      repeat (3) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mrst_stim", 32'(stim), 0);
      chk("mrst_valid", 32'(valid), 0);
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_pc", pc, 0);
      tick();
      pulse_start(11);
      for (int i = 0; i < 11; i++) begin
         chk("mrst_rerun", 32'(stim), 32'(i % 4));
         tick();
      end
      repeat (2) tick();

`ifdef STIM_SEQ_LOOP_EN
      loop = 1'b1;
      pulse_start(3);
      for (int i = 0; i < 8; i++) begin
         chk("loop_stim", 32'(stim), 32'(i % 3));
         chk("loop_pc", pc, 32'(i + 1));
         chk("loop_done", 32'(done), 0);
         tick();
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      loop = 1'b0;
      chk("loop_stop_valid", 32'(valid), 0);
      chk("loop_stop_done", 32'(done), 0);
      tick();
`endif

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stim_sequencer.md
# stim_sequencer

Synthesizable stimulus replay engine: holds a DEPTH-entry table of WIDTH-bit input vectors and presents one vector per clock on `stim`, so a DUT can be driven from a stored program in simulation or on an emulation board. It generalises the fixed 2-bit, 11-entry testbench program counter into a parametrised block. It adds host table loading, programmable run length, start/stop control, completion status and optional looping. It sits between a control/host interface and the DUT input pins.

## Interface
Parameters:
- `WIDTH`, 2, bits per stimulus vector.
- `DEPTH`, 11, table entries.
- `AW`, $clog2(DEPTH), table address / length width.
- `CNT_W`, 32, width of the vector counter `pc`.

Ports (one clock; reset is synchronous and active-low):
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset, sampled on `clock`.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  AW  table write address.
- `wr_data`  in  WIDTH  table write data.
- `len`  in  AW+1  entries to replay (sampled at start).
- `start`  in  1  start request (level sampled each edge).
- `stop`  in  1  abort request.
- `loop`  in  1  loop-mode request (sampled at start; present only with `STIM_SEQ_LOOP_EN`).
- `stim`  out  WIDTH  current stimulus vector.
- `valid`  out  1  `stim` is a live table entry this cycle.
- `busy`  out  1  state is RUN.
- `done`  out  1  one-cycle pulse on normal completion.
- `pc`  out  CNT_W  vectors presented since last start.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1, `stop`=0, effective length L≥1 → RUN. Same edge: `stim`←table[0], `valid`←1, `addr`←1, `pc`←1.
  - L = min(`len`, DEPTH).
  - `len`=0 → DONE directly. No vector presented; `pc`←0.
- RUN, each edge:
  - If `addr`<L: `stim`←table[addr], `addr`++, `pc`++.
  - If `addr`==L (last entry already presented), non-loop: `valid`←0, go to DONE.
  - If `addr`==L, loop mode: `stim`←table[0], `addr`←1, `pc`++. No gap cycle.
- DONE: `done`=1 for exactly this cycle, `valid`=0, then IDLE unconditionally.
- `stop`=1:
  - In RUN: next edge `valid`←0, IDLE, no `done` pulse.
  - In IDLE with `start`: `stop` wins and `start` is ignored.
- `start` in RUN or DONE is ignored.
- `stim` holds its last presented value when `valid`=0.
- `pc` wraps modulo 2^CNT_W.
- Table writes:
  - Accepted only when `busy`=0; writes during RUN are dropped.
  - `wr_addr`≥DEPTH is dropped.
  - A write in the same cycle as an accepted `start` lands; the replay reads the old entry 0 that cycle.
- Table contents are not cleared by reset.

## Timing
- Reset (`reset`=0 at an edge): state IDLE, `stim`=0, `valid`=0, `busy`=0, `done`=0, `pc`=0, `addr`=0. Reset overrides all other inputs, including mid-run.
- Start latency: vector 0 appears on the edge that samples `start`, so it is visible one cycle after `start` is asserted.
- Throughput: one vector per clock. A non-loop run of L entries shows `valid`=1 for L consecutive cycles, then `done` for 1 cycle.
- Minimum restart: `start` sampled in the cycle after `done` begins a new run.
- All outputs are registered; the table read is combinational from a register array.

## Configuration
- `STIM_SEQ_LOOP_EN` defined:
  - `loop` port exists.
  - `loop`=1 at start → wrap after entry L-1 and run until `stop` or reset; `done` never pulses.
- `STIM_SEQ_LOOP_EN` undefined: `loop` port is absent and every run is one-shot.

## Structure
- Package `stim_seq_pkg`: state enum (IDLE/RUN/DONE) and the default WIDTH/DEPTH constants.
- Sub-module `stim_seq_mem`: DEPTH×WIDTH register array, synchronous write port, asynchronous read port.
- Top-level `stim_sequencer` holds the FSM, address and counter.

## Test plan
- Reset mid-run: load table 0..10 = {0,1,2,3,0,1,2,3,0,1,2}, `len`=11, start; drop `reset` on cycle 4 → next edge all outputs 0, IDLE; table contents intact on rerun.
- One-shot full table: same table, `len`=11, pulse `start` → `stim` 0,1,2,3,0,1,2,3,0,1,2 on 11 consecutive cycles with `valid`=1, then `done`=1 one cycle, `pc`=11, `stim` holds 2.
- Length edge cases:
  - `len`=1 → single vector table[0], then `done`.
  - `len`=0 → `done` next cycle with `valid` never high.
  - `len`=15 → clamped to 11 vectors.
- Stop and contention:
  - `stop` on the 5th RUN cycle → `valid` low next edge, no `done`, `pc`=5.
  - `start`+`stop` together in IDLE → stays IDLE.
  - `start` during RUN → no restart.
- Write blocking: write `wr_addr`=2, `wr_data`=3 during RUN → dropped; same write while idle → next run shows 3 at the 3rd vector; `wr_addr`=11 → dropped.
- Loop (`STIM_SEQ_LOOP_EN`): `loop`=1, `len`=3 → `stim` 0,1,2,0,1,2… with no gap, `pc` increments every cycle, no `done`; `stop` ends the run.
